onedconv_psum_buffer: RTL and testbench

- Output-side partner of the 1-D convolution row controller.
- Consumes its Set_En, O_En, Wptclr and Rptclr strobes and holds one output-feature-map row of partial sums: it writes and accumulates products on Set_En, then reads them out on O_En.
- Sits between the PE product output and the downstream output-map writer, with a valid/ready handshake on the read side.

---
 rtl/onedconv_psum_buffer.sv | 164 ++++++++++++++++
 tb/tb_onedconv_psum_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onedconv_psum_buffer.sv
// Partial-sum row buffer for the 1-D convolution datapath: accumulates PE products
// per output column, then drains the row through a valid/ready read port.
module onedconv_psum_buffer #(
    parameter int DATA_W             = 16,
    parameter int ACC_W              = 24,
    parameter int BITWIDTH_OF_COLUMS = 11,
    parameter int DEPTH              = 1024,
    parameter int CLEAR_ON_READ      = 1
) (
    input  logic                          ONEDCONV_PSUM_BUFFER_Clk,
    input  logic                          ONEDCONV_PSUM_BUFFER_Reset,
    input  logic                          ONEDCONV_PSUM_BUFFER_Set_En,
    input  logic                          ONEDCONV_PSUM_BUFFER_First_Pass,
    input  logic [DATA_W-1:0]             ONEDCONV_PSUM_BUFFER_Product,
    input  logic                          ONEDCONV_PSUM_BUFFER_Wptclr,
    input  logic                          ONEDCONV_PSUM_BUFFER_Rptclr,
    input  logic                          ONEDCONV_PSUM_BUFFER_O_En,
    input  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_PSUM_BUFFER_Of_Colums,
    input  logic                          ONEDCONV_PSUM_BUFFER_Out_Ready,
    output logic [ACC_W-1:0]              ONEDCONV_PSUM_BUFFER_Out_Data,
    output logic                          ONEDCONV_PSUM_BUFFER_Out_Valid,
    output logic                          ONEDCONV_PSUM_BUFFER_Busy,
    output logic                          ONEDCONV_PSUM_BUFFER_Overflow,
    output logic                          ONEDCONV_PSUM_BUFFER_Overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [ACC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_outData;
    logic             r_outValid;
    logic             r_outLast;
    logic             r_overflow;
    logic             r_overrun;

    logic [31:0]             w_colsExt;
    logic [31:0]             w_len;
    logic [PTR_W-1:0]        w_lastIdx;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_old;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_sat;
    logic [ACC_W-1:0]        w_satVal;
    logic [ACC_W-1:0]        w_wrVal;
    logic                    w_hazard;
    logic                    w_rdAccept;
    logic                    w_rdBlocked;
    logic                    w_drainDone;

    // Row length is clamped so a zero count still behaves as a one-entry row.
    assign w_colsExt = 32'(ONEDCONV_PSUM_BUFFER_Of_Colums);
    assign w_len     = (w_colsExt == 32'd0)      ? 32'd1 :
                       (w_colsExt > 32'(DEPTH))  ? 32'(DEPTH) : w_colsExt;
    assign w_lastIdx = PTR_W'(w_len - 32'd1);

    assign w_ext    = ACC_W'($signed(ONEDCONV_PSUM_BUFFER_Product));
    assign w_old    = $signed(r_mem[r_wptr]);
    assign w_sum    = {w_old[ACC_W-1], w_old} + {w_ext[ACC_W-1], w_ext};
    assign w_sat    = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_satVal = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign w_wrVal  = ONEDCONV_PSUM_BUFFER_First_Pass ? w_ext :
                      (w_sat ? w_satVal : w_sum[ACC_W-1:0]);

    assign w_hazard    = ONEDCONV_PSUM_BUFFER_Set_En && (r_wptr == r_rptr);
    assign w_rdAccept  = ONEDCONV_PSUM_BUFFER_O_En && (!r_outValid || ONEDCONV_PSUM_BUFFER_Out_Ready);
    assign w_rdBlocked = ONEDCONV_PSUM_BUFFER_O_En && r_outValid && !ONEDCONV_PSUM_BUFFER_Out_Ready;
    assign w_drainDone = r_outValid && ONEDCONV_PSUM_BUFFER_Out_Ready && r_outLast && !w_rdAccept;

    // A same-address write beats clear-on-read so the freshly accumulated value survives.
    always_ff @(posedge ONEDCONV_PSUM_BUFFER_Clk) begin
        if (ONEDCONV_PSUM_BUFFER_Set_En) begin
            r_mem[r_wptr] <= w_wrVal;
        end
        if ((CLEAR_ON_READ != 0) && w_rdAccept && !w_hazard) begin
            r_mem[r_rptr] <= '0;
        end
    end

    always_ff @(posedge ONEDCONV_PSUM_BUFFER_Clk or negedge ONEDCONV_PSUM_BUFFER_Reset) begin
        if (!ONEDCONV_PSUM_BUFFER_Reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (ONEDCONV_PSUM_BUFFER_Wptclr) begin
                r_wptr <= '0;
            end else if (ONEDCONV_PSUM_BUFFER_Set_En) begin
                r_wptr <= (r_wptr >= w_lastIdx) ? '0 : r_wptr + 1'b1;
            end
            if (ONEDCONV_PSUM_BUFFER_Rptclr) begin
                r_rptr <= '0;
            end else if (w_rdAccept) begin
                r_rptr <= (r_rptr >= w_lastIdx) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    // r_outLast remembers that the pending word is the final column of the row.
    always_ff @(posedge ONEDCONV_PSUM_BUFFER_Clk or negedge ONEDCONV_PSUM_BUFFER_Reset) begin
        if (!ONEDCONV_PSUM_BUFFER_Reset) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_rdAccept) begin
                r_outValid <= 1'b1;
                r_outData  <= w_hazard ? w_wrVal : r_mem[r_rptr];
                r_outLast  <= (r_rptr >= w_lastIdx);
            end else if (ONEDCONV_PSUM_BUFFER_Out_Ready) begin
                r_outValid <= 1'b0;
            end
            if (ONEDCONV_PSUM_BUFFER_Set_En && !ONEDCONV_PSUM_BUFFER_First_Pass && w_sat) begin
                r_overflow <= 1'b1;
            end
            if (w_rdBlocked) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge ONEDCONV_PSUM_BUFFER_Clk or negedge ONEDCONV_PSUM_BUFFER_Reset) begin
        if (!ONEDCONV_PSUM_BUFFER_Reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rdAccept) begin
                        r_state <= S_DRAIN;
                    end else if (ONEDCONV_PSUM_BUFFER_Set_En) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_rdAccept) begin
                        r_state <= S_DRAIN;
                    end else if (ONEDCONV_PSUM_BUFFER_Wptclr && !ONEDCONV_PSUM_BUFFER_Set_En) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_drainDone) begin
                        r_state <= ONEDCONV_PSUM_BUFFER_Set_En ? S_ACCUM : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ONEDCONV_PSUM_BUFFER_Out_Data  = r_outData;
    assign ONEDCONV_PSUM_BUFFER_Out_Valid = r_outValid;
    assign ONEDCONV_PSUM_BUFFER_Busy      = (r_state != S_IDLE);
    assign ONEDCONV_PSUM_BUFFER_Overflow  = r_overflow;
    assign ONEDCONV_PSUM_BUFFER_Overrun   = r_overrun;

endmodule

// File: tb/tb_onedconv_psum_buffer.sv
// Scoreboard bench for onedconv_psum_buffer: directed scenarios plus random traffic,
// checked against an array/queue model of the partial-sum row.
module tb_onedconv_psum_buffer;

    localparam int ACC_MAX  = 8388607;
    localparam int ACC_MIN  = -8388608;
    localparam int M_IDLE   = 0;
    localparam int M_ACCUM  = 1;
    localparam int M_DRAIN  = 2;

    logic               clk;
    logic               rst_n;
    logic               set;
    logic               fp;
    logic signed [15:0] prod;
    logic               wclr;
    logic               rclr;
    logic               oen;
    logic [10:0]        cols;
    logic               ready;
    logic signed [23:0] outData;
    logic               outValid;
    logic               busy;
    logic               overflow;
    logic               overrun;

    int  mMem [1024];
    int  mWp = 0;
    int  mRp = 0;
    int  mState = M_IDLE;
    bit  mValid = 0;
    bit  mLast = 0;
    bit  mOvf = 0;
    bit  mOvr = 0;
    int  scoreQ [$];
    int  nTests = 0;
    int  nFail = 0;

    onedconv_psum_buffer dut (
        .ONEDCONV_PSUM_BUFFER_Clk        (clk),
        .ONEDCONV_PSUM_BUFFER_Reset      (rst_n),
        .ONEDCONV_PSUM_BUFFER_Set_En     (set),
        .ONEDCONV_PSUM_BUFFER_First_Pass (fp),
        .ONEDCONV_PSUM_BUFFER_Product    (prod),
        .ONEDCONV_PSUM_BUFFER_Wptclr     (wclr),
        .ONEDCONV_PSUM_BUFFER_Rptclr     (rclr),
        .ONEDCONV_PSUM_BUFFER_O_En       (oen),
        .ONEDCONV_PSUM_BUFFER_Of_Colums  (cols),
        .ONEDCONV_PSUM_BUFFER_Out_Ready  (ready),
        .ONEDCONV_PSUM_BUFFER_Out_Data   (outData),
        .ONEDCONV_PSUM_BUFFER_Out_Valid  (outValid),
        .ONEDCONV_PSUM_BUFFER_Busy       (busy),
        .ONEDCONV_PSUM_BUFFER_Overflow   (overflow),
        .ONEDCONV_PSUM_BUFFER_Overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int satAdd(input int a, input int b, output bit hit);
        longint s;
        s = longint'(a) + longint'(b);
        hit = 1'b0;
        if (s > ACC_MAX) begin
            hit = 1'b1;
            return ACC_MAX;
        end
        if (s < ACC_MIN) begin
            hit = 1'b1;
            return ACC_MIN;
        end
        return int'(s);
    endfunction

    // Advances the model by one clock using the inputs that the DUT just sampled.
    task automatic modelStep();
        int  len;
        bit  acc;
        bit  blk;
        bit  haz;
        bit  hit;
        bit  done;
        int  wv;
        len  = (cols == 0) ? 1 : ((cols > 1024) ? 1024 : int'(cols));
        acc  = oen && (!mValid || ready);
        blk  = oen && mValid && !ready;
        haz  = set && (mWp == mRp);
        hit  = 1'b0;
        wv   = 0;
        if (set) begin
            if (fp) wv = int'(prod);
            else    wv = satAdd(mMem[mWp], int'(prod), hit);
        end
        done = mValid && ready && mLast && !acc;
        case (mState)
            M_IDLE:  if (acc) mState = M_DRAIN; else if (set) mState = M_ACCUM;
            M_ACCUM: if (acc) mState = M_DRAIN; else if (wclr && !set) mState = M_IDLE;
            default: if (done) mState = set ? M_ACCUM : M_IDLE;
        endcase
        if (acc) begin
            scoreQ.push_back(haz ? wv : mMem[mRp]);
            if (!haz) mMem[mRp] = 0;
            mLast = (mRp == len - 1);
        end
        if (set) mMem[mWp] = wv;
        if (hit) mOvf = 1'b1;
        if (blk) mOvr = 1'b1;
        mValid = acc ? 1'b1 : (ready ? 1'b0 : mValid);
        mWp = wclr ? 0 : (set ? (mWp + 1) % len : mWp);
        mRp = rclr ? 0 : (acc ? (mRp + 1) % len : mRp);
    endtask

    task automatic modelReset();
        mWp = 0;
        mRp = 0;
        mState = M_IDLE;
        mValid = 1'b0;
        mLast = 1'b0;
        mOvf = 1'b0;
        mOvr = 1'b0;
        scoreQ.delete();
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic signed [15:0] p,
                                 input logic wc, input logic rc, input logic o, input logic r);
        set = s; fp = f; prod = p; wclr = wc; rclr = rc; oen = o; ready = r;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic newRow(input logic [10:0] c);
        cols = c;
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
    endtask

    task automatic readN(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic resetPulse();
        set = 0; fp = 0; prod = 0; wclr = 0; rclr = 0; oen = 0; ready = 0;
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_valid", int'(outValid), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares status every cycle and data whenever a word is presented.
    always @(negedge clk) begin
        checkOutput("busy", int'(busy), (mState != M_IDLE) ? 1 : 0);
        checkOutput("out_valid", int'(outValid), int'(mValid));
        checkOutput("overflow", int'(overflow), int'(mOvf));
        checkOutput("overrun", int'(overrun), int'(mOvr));
        if (outValid) begin
            if (scoreQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL out_data: got %0d, expected no word pending", int'(outData));
            end else begin
                checkOutput("out_data", int'(outData), scoreQ[0]);
                if (ready) void'(scoreQ.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        set = 0; fp = 0; prod = 0; wclr = 0; rclr = 0; oen = 0; ready = 1; cols = 11'd4;
        #1;
        rst_n = 1'b0;
        #11;
        checkOutput("rst_out_valid", int'(outValid), 0);
        checkOutput("rst_out_data", int'(outData), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Overwrite then drain, then re-read the cleared entries.
        cols = 11'd4;
        for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 16'(i), 0, 0, 0, 1);
        readN(4);
        idle(2);
        readN(4);
        idle(2);

        // Two-pass accumulation.
        newRow(11'd3);
        applyStimulus(1, 1, 5, 0, 0, 0, 1);
        applyStimulus(1, 1, -2, 0, 0, 0, 1);
        applyStimulus(1, 1, 7, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 1);
        readN(3);
        idle(2);

        // Positive saturation on a single-entry row.
        newRow(11'd1);
        applyStimulus(1, 1, 16'sh7FFF, 0, 0, 0, 1);
        for (int i = 0; i < 256; i++) applyStimulus(1, 0, 16'sh7FFF, 0, 0, 0, 1);
        readN(1);
        idle(3);
        checkOutput("overflow_sticky", int'(overflow), 1);

        // Backpressure with dropped reads.
        newRow(11'd2);
        applyStimulus(1, 1, 10, 0, 0, 0, 1);
        applyStimulus(1, 1, 20, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        readN(1);
        idle(2);
        checkOutput("overrun_sticky", int'(overrun), 1);

        // Same-address forwarding and Wptclr/Set_En priority.
        newRow(11'd4);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 4, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        readN(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 3, 0, 0, 1, 1);
        readN(4);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(1, 1, 9, 0, 0, 0, 1);
        applyStimulus(1, 1, 11, 1, 0, 0, 1);
        applyStimulus(1, 1, 13, 0, 0, 0, 1);
        readN(3);
        idle(2);

        // Asynchronous reset with a word pending, then zero-length row.
        newRow(11'd3);
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 2, 0, 0, 0, 1);
        applyStimulus(1, 1, 3, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        resetPulse();
        cols = 11'd0;
        applyStimulus(1, 1, 5, 0, 0, 0, 1);
        applyStimulus(1, 0, 6, 0, 0, 0, 1);
        readN(2);
        idle(2);

        // Random traffic over several row lengths, including clamped ones.
        for (int ph = 0; ph < 6; ph++) begin
            logic [10:0] c;
            int len;
            if (ph == 2)      c = 11'd0;
            else if (ph == 4) c = 11'd1500;
            else              c = 11'($urandom_range(1, 8));
            len = (c == 0) ? 1 : ((c > 1024) ? 1024 : int'(c));
            newRow(c);
            for (int i = 0; i < len; i++) applyStimulus(1, 1, 16'($urandom), 0, 0, 0, 1);
            for (int i = 0; i < 150; i++) begin
                applyStimulus(($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                              16'($urandom), ($urandom_range(0, 19) == 0),
                              ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
                              ($urandom_range(0, 9) < 7));
            end
            idle(4);
        end

        idle(4);
        checkOutput("scoreboard_empty", scoreQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
